// File: rtl/stu_upstream_pkt_buf.sv
// Per-PE upstream packet buffer: framing-checked flit FIFO that releases packets
// store-and-forward, falling back to cut-through when a packet overflows the buffer.
module stu_upstream_pkt_buf #(
    parameter int DATA_W = 64,
    parameter int TYPE_W = 2,
    parameter int OOB_W  = 32,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              src__stub__valid,
    input  logic [1:0]        src__stub__cntl,
    input  logic [TYPE_W-1:0] src__stub__type,
    input  logic [DATA_W-1:0] src__stub__data,
    input  logic [OOB_W-1:0]  src__stub__oob_data,
    output logic              stub__src__ready,
    output logic              pe__stu__valid,
    output logic [1:0]        pe__stu__cntl,
    output logic [TYPE_W-1:0] pe__stu__type,
    output logic [DATA_W-1:0] pe__stu__data,
    output logic [OOB_W-1:0]  pe__stu__oob_data,
    input  logic              stu__pe__ready,
    output logic              stub__sys__frame_err,
    output logic              stub__sys__empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = 2 + TYPE_W + DATA_W + OOB_W;

    localparam logic [1:0] CNTL_MOM     = 2'b00;
    localparam logic [1:0] CNTL_SOM     = 2'b01;
    localparam logic [1:0] CNTL_EOM     = 2'b10;
    localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

    typedef enum logic {ST_IDLE, ST_SEND} state_t;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          in_pkt_q, in_pkt_d;
    logic          frame_err_q, frame_err_d;
    logic          ready_en_q, ready_en_d;
    state_t        state_q, state_d;

    logic          full, empty, wr_fire, wr_en, rd_en, out_valid;
    logic [EW-1:0] head;
    logic [1:0]    head_cntl;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign head_cntl = head[EW-1 -: 2];

    // ready_en_q keeps ready low until the first edge after reset release
    assign stub__src__ready = ready_en_q && !full;
    assign wr_fire          = src__stub__valid && stub__src__ready;

    always_comb begin
        wr_en       = 1'b0;
        in_pkt_d    = in_pkt_q;
        frame_err_d = frame_err_q;
        ready_en_d  = 1'b1;
        if (wr_fire) begin
            if (!in_pkt_q) begin
                case (src__stub__cntl)
                    CNTL_SOM: begin
                        wr_en    = 1'b1;
                        in_pkt_d = 1'b1;
                    end
                    CNTL_SOM_EOM: wr_en = 1'b1;
                    default:      frame_err_d = 1'b1;
                endcase
            end else begin
                case (src__stub__cntl)
                    CNTL_MOM: wr_en = 1'b1;
                    CNTL_EOM: begin
                        wr_en    = 1'b1;
                        in_pkt_d = 1'b0;
                    end
                    default:  frame_err_d = 1'b1;
                endcase
            end
        end
    end

    // In IDLE a packet is released once its EOM is resident, or when the buffer is full
    always_comb begin
        out_valid = 1'b0;
        state_d   = state_q;
        case (state_q)
            ST_IDLE: out_valid = !empty && head_cntl[0] && ((pkt_cnt_q != '0) || full);
            ST_SEND: out_valid = !empty;
            default: out_valid = 1'b0;
        endcase
        rd_en = out_valid && stu__pe__ready;
        if (rd_en) begin
            if (state_q == ST_IDLE && head_cntl == CNTL_SOM) state_d = ST_SEND;
            if (state_q == ST_SEND && head_cntl == CNTL_EOM) state_d = ST_IDLE;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
        pkt_cnt_d = pkt_cnt_q;
        case ({wr_en && src__stub__cntl[1], rd_en && head_cntl[1]})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CW'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - CW'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
            in_pkt_q    <= 1'b0;
            frame_err_q <= 1'b0;
            ready_en_q  <= 1'b0;
            state_q     <= ST_IDLE;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            in_pkt_q    <= in_pkt_d;
            frame_err_q <= frame_err_d;
            ready_en_q  <= ready_en_d;
            state_q     <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {src__stub__cntl, src__stub__type,
                                        src__stub__data, src__stub__oob_data};
        end
    end

    assign pe__stu__valid = out_valid;
    assign {pe__stu__cntl, pe__stu__type, pe__stu__data, pe__stu__oob_data} =
        out_valid ? head : '0;
    assign stub__sys__frame_err = frame_err_q;
    assign stub__sys__empty     = empty;

    // The input checker guarantees every packet in the FIFO begins with a SOM
    a_idle_head_is_som : assert property (@(posedge clk) disable iff (!reset_poweron)
        (state_q == ST_IDLE && !empty) |-> head_cntl[0]);

endmodule

// File: tb/tb_stu_upstream_pkt_buf.sv
// Bench for stu_upstream_pkt_buf: directed scenarios plus randomized packet traffic,
// checked by a queue-based reference model and a negedge monitor.
module tb_stu_upstream_pkt_buf;
    localparam int DEPTH = 8;
    localparam logic [1:0] MOM = 2'b00, SOM = 2'b01, EOM = 2'b10, SOM_EOM = 2'b11;

    typedef struct packed {
        logic [1:0]  c;
        logic [1:0]  t;
        logic [63:0] d;
        logic [31:0] o;
    } flit_t;

    logic        clk = 1'b0;
    logic        reset_poweron = 1'b0;
    logic        src__stub__valid = 1'b0;
    logic [1:0]  src__stub__cntl = '0;
    logic [1:0]  src__stub__type = '0;
    logic [63:0] src__stub__data = '0;
    logic [31:0] src__stub__oob_data = '0;
    logic        stub__src__ready;
    logic        pe__stu__valid;
    logic [1:0]  pe__stu__cntl;
    logic [1:0]  pe__stu__type;
    logic [63:0] pe__stu__data;
    logic [31:0] pe__stu__oob_data;
    logic        stu__pe__ready = 1'b0;
    logic        stub__sys__frame_err;
    logic        stub__sys__empty;

    int n_tests = 0;
    int n_fail  = 0;
    bit rnd_mode = 1'b0;

    stu_upstream_pkt_buf #(.DATA_W(64), .TYPE_W(2), .OOB_W(32), .DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .reset_poweron        (reset_poweron),
        .src__stub__valid     (src__stub__valid),
        .src__stub__cntl      (src__stub__cntl),
        .src__stub__type      (src__stub__type),
        .src__stub__data      (src__stub__data),
        .src__stub__oob_data  (src__stub__oob_data),
        .stub__src__ready     (stub__src__ready),
        .pe__stu__valid       (pe__stu__valid),
        .pe__stu__cntl        (pe__stu__cntl),
        .pe__stu__type        (pe__stu__type),
        .pe__stu__data        (pe__stu__data),
        .pe__stu__oob_data    (pe__stu__oob_data),
        .stu__pe__ready       (stu__pe__ready),
        .stub__sys__frame_err (stub__sys__frame_err),
        .stub__sys__empty     (stub__sys__empty)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model + monitor ----------------
    flit_t exp_q[$];
    flit_t cur, held, e;
    bit    m_in_pkt, m_err, mid_out, hold_v, has_end, exp_v, tb_up;

    // The block accepts input from the first edge after reset release
    always @(posedge clk or negedge reset_poweron)
        if (!reset_poweron) tb_up <= 1'b0;
        else                tb_up <= 1'b1;

    always @(negedge clk) begin
        if (!reset_poweron) begin
            exp_q.delete();
            m_in_pkt = 0; m_err = 0; mid_out = 0; hold_v = 0;
        end else begin
            has_end = 0;
            foreach (exp_q[i]) if (exp_q[i].c[1]) has_end = 1;
            exp_v = (exp_q.size() > 0) && (mid_out || has_end || exp_q.size() == DEPTH);
            chk("valid", pe__stu__valid, exp_v);
            chk("src_ready", stub__src__ready, tb_up && (exp_q.size() < DEPTH));
            chk("empty", stub__sys__empty, exp_q.size() == 0);
            chk("frame_err", stub__sys__frame_err, m_err);
            cur = {pe__stu__cntl, pe__stu__type, pe__stu__data, pe__stu__oob_data};
            if (hold_v) chk("stall_hold", cur, held);
            hold_v = 0;
            if (!pe__stu__valid) begin
                chk("idle_zero", cur, '0);
            end else if (stu__pe__ready) begin
                if (exp_q.size() == 0) begin
                    chk("pop_empty", 1'b1, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    chk("flit", cur, e);
                    if (e.c == SOM) mid_out = 1;
                    else if (e.c == EOM) mid_out = 0;
                end
            end else begin
                hold_v = 1;
                held   = cur;
            end
            if (src__stub__valid && stub__src__ready) begin
                cur = {src__stub__cntl, src__stub__type, src__stub__data, src__stub__oob_data};
                if (!m_in_pkt) begin
                    if (cur.c == SOM) begin exp_q.push_back(cur); m_in_pkt = 1; end
                    else if (cur.c == SOM_EOM) exp_q.push_back(cur);
                    else m_err = 1;
                end else begin
                    if (cur.c == MOM) exp_q.push_back(cur);
                    else if (cur.c == EOM) begin exp_q.push_back(cur); m_in_pkt = 0; end
                    else m_err = 1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_mode) stu__pe__ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic put(input logic [1:0] c, input logic [1:0] t, input logic [63:0] d,
                       input logic [31:0] o);
        bit done = 0;
        src__stub__valid = 1'b1;
        src__stub__cntl = c; src__stub__type = t; src__stub__data = d; src__stub__oob_data = o;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            done = stub__src__ready;
            step();
        end
        src__stub__valid = 1'b0;
        if (!done) chk("put_timeout", 1'b0, 1'b1);
    endtask

    task automatic put_rnd(input logic [1:0] c);
        put(c, 2'($urandom), {$urandom, $urandom}, $urandom);
    endtask

    initial begin
        int len;
        logic [1:0] c;
        #2;
        chk("rst_valid", pe__stu__valid, 1'b0);
        chk("rst_ready", stub__src__ready, 1'b0);
        chk("rst_empty", stub__sys__empty, 1'b1);
        chk("rst_err", stub__sys__frame_err, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_poweron = 1'b1;
        step();
        chk("post_rst_ready", stub__src__ready, 1'b1);

        // single-flit packet latency
        stu__pe__ready = 1'b1;
        chk("t1_pre_valid", pe__stu__valid, 1'b0);
        put(SOM_EOM, 2'b01, 64'hA5, 32'h1);
        chk("t1_valid", pe__stu__valid, 1'b1);
        chk("t1_fields", {pe__stu__cntl, pe__stu__type, pe__stu__data, pe__stu__oob_data},
            {SOM_EOM, 2'b01, 64'hA5, 32'h1});
        step();
        chk("t1_empty", stub__sys__empty, 1'b1);

        // store-and-forward with stalls
        put(SOM, 2'b10, 64'h100, 32'h10);
        chk("t2_som_hold", pe__stu__valid, 1'b0);
        put(MOM, 2'b10, 64'h101, 32'h11);
        chk("t2_mom_hold", pe__stu__valid, 1'b0);
        put(EOM, 2'b10, 64'h102, 32'h12);
        chk("t2_release", pe__stu__valid, 1'b1);
        chk("t2_head", pe__stu__cntl, SOM);
        for (int i = 0; i < 8; i++) begin
            stu__pe__ready = (i % 2 == 1);
            step();
        end
        stu__pe__ready = 1'b1;
        repeat (3) step();
        chk("t2_empty", stub__sys__empty, 1'b1);

        // cut-through on an oversize packet
        for (int k = 0; k < 10; k++) begin
            c = (k == 0) ? SOM : (k == 9) ? EOM : MOM;
            put(c, 2'b11, 64'h200 + 64'(k), 32'(k));
            if (k == 7) begin
                chk("t3_full_ready", stub__src__ready, 1'b0);
                chk("t3_cut_valid", pe__stu__valid, 1'b1);
                chk("t3_cut_som", pe__stu__cntl, SOM);
            end
        end
        repeat (12) step();
        chk("t3_empty", stub__sys__empty, 1'b1);

        // framing errors
        chk("t4_err_clear", stub__sys__frame_err, 1'b0);
        put(EOM, 2'b00, 64'hDEAD, 32'h0);
        chk("t4_err_set", stub__sys__frame_err, 1'b1);
        chk("t4_drop_empty", stub__sys__empty, 1'b1);
        put(SOM, 2'b01, 64'h300, 32'h30);
        put(MOM, 2'b01, 64'h301, 32'h31);
        put(SOM, 2'b01, 64'hBAD, 32'hBAD);
        put(EOM, 2'b01, 64'h302, 32'h32);
        repeat (5) step();
        chk("t4_empty", stub__sys__empty, 1'b1);

        // fill while stalled, then release
        stu__pe__ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) put(SOM_EOM, 2'b10, 64'h400 + 64'(k), 32'(k));
        chk("t5_full_ready", stub__src__ready, 1'b0);
        chk("t5_full_valid", pe__stu__valid, 1'b1);
        stu__pe__ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            step();
            chk("t5_drain_valid", pe__stu__valid, k < DEPTH - 1);
        end
        for (int k = 0; k < 6; k++) begin
            put(SOM_EOM, 2'b00, 64'h500 + 64'(k), 32'(k));
            chk("t5_stream_valid", pe__stu__valid, 1'b1);
        end
        step();
        chk("t5_empty", stub__sys__empty, 1'b1);

        // reset mid-packet
        put(SOM, 2'b01, 64'h600, 32'h60);
        put(MOM, 2'b01, 64'h601, 32'h61);
        reset_poweron = 1'b0;
        #1;
        chk("t6_rst_valid", pe__stu__valid, 1'b0);
        chk("t6_rst_ready", stub__src__ready, 1'b0);
        chk("t6_rst_empty", stub__sys__empty, 1'b1);
        chk("t6_rst_fields", {pe__stu__cntl, pe__stu__type, pe__stu__data, pe__stu__oob_data}, '0);
        chk("t6_rst_err", stub__sys__frame_err, 1'b0);
        step();
        reset_poweron = 1'b1;
        step();
        chk("t6_ready", stub__src__ready, 1'b1);
        chk("t6_no_stale", pe__stu__valid, 1'b0);
        put(SOM_EOM, 2'b11, 64'h700, 32'h70);
        chk("t6_new_valid", pe__stu__valid, 1'b1);
        chk("t6_new_data", pe__stu__data, 64'h700);
        step();

        // randomized traffic
        rnd_mode = 1'b1;
        repeat (250) begin
            len = $urandom_range(1, 12);
            if ($urandom_range(0, 9) == 0) put_rnd($urandom_range(0, 1) ? EOM : MOM);
            for (int k = 0; k < len; k++) begin
                c = (len == 1) ? SOM_EOM : (k == 0) ? SOM : (k == len - 1) ? EOM : MOM;
                put_rnd(c);
                if (k < len - 1 && len > 1 && $urandom_range(0, 19) == 0)
                    put_rnd($urandom_range(0, 1) ? SOM : SOM_EOM);
            end
            if ($urandom_range(0, 3) == 0) step();
        end
        rnd_mode = 1'b0;
        stu__pe__ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() > 0; i++) step();
        chk("drain_left", exp_q.size(), 0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
